// File: rtl/field_addsub_lanes.sv
// field_addsub_lanes: modular add/subtract over GF(Q) for LANES packed operand pairs.
// Lanes are processed one after another. A single (NBITS+1)-bit adder with carry-out
// is shared across three steps: negate (Q - b), add, and conditional reduce.
// Optional feature macro: FIELD_ADDSUB_RANGE_CHK_EN adds the oor port and the
// operand range comparators.
//
// state | meaning
// IDLE  | waiting for a rising edge of en; c valid, ready high
// NEG   | acc = Q - b_i (0 when b_i == 0), subtract mode only
// ADD   | acc = a_i + (sub ? acc : b_i)
// RED   | c_i = (acc >= Q) ? acc - Q : acc, advance lane or finish
// DONE  | last lane written; ready and ready_pulse rise next cycle
module field_addsub_lanes #(
    parameter int unsigned NBITS = 61,
    parameter logic [63:0] Q     = 64'h1FFF_FFFF_FFFF_FFFF,
    parameter int unsigned LANES = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   en,
    input  logic                   sub,
    input  logic [LANES*NBITS-1:0] a,
    input  logic [LANES*NBITS-1:0] b,
    output logic                   ready,
    output logic                   ready_pulse,
    output logic [LANES*NBITS-1:0] c
`ifdef FIELD_ADDSUB_RANGE_CHK_EN
    ,
    output logic                   oor
`endif
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [NBITS:0] QX = Q[NBITS:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NEG  = 3'd1,
        S_ADD  = 3'd2,
        S_RED  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   en_dly;
    logic                   start;
    logic                   load;
    logic                   do_neg;
    logic                   do_add;
    logic                   do_red;
    logic                   fin;
    logic                   last;
    logic                   sub_reg;
    logic [LANES*NBITS-1:0] a_reg;
    logic [LANES*NBITS-1:0] b_reg;
    logic [LW-1:0]          lane;
    logic [NBITS:0]         acc;
    logic [NBITS-1:0]       a_lane;
    logic [NBITS-1:0]       b_lane;
    logic [NBITS:0]         add_x;
    logic [NBITS:0]         add_y;
    logic                   add_cin;
    logic [NBITS:0]         add_sum;
    logic                   add_co;
    logic [NBITS-1:0]       red_val;

    assign start = en & ~en_dly;
    assign last  = (lane == LW'(LANES - 1));

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; starts outside IDLE are dropped, not queued
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = sub ? S_NEG : S_ADD;
            S_NEG:  state_nxt = S_ADD;
            S_ADD:  state_nxt = S_RED;
            S_RED:  state_nxt = last ? S_DONE : (sub_reg ? S_NEG : S_ADD);
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        load   = 1'b0;
        do_neg = 1'b0;
        do_add = 1'b0;
        do_red = 1'b0;
        fin    = 1'b0;
        case (state)
            S_IDLE: load   = start;
            S_NEG:  do_neg = 1'b1;
            S_ADD:  do_add = 1'b1;
            S_RED:  do_red = 1'b1;
            S_DONE: fin    = 1'b1;
            default: ;
        endcase
    end

    // Select the operands of the active lane
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) begin
                a_lane = a_reg[i*NBITS +: NBITS];
                b_lane = b_reg[i*NBITS +: NBITS];
            end
        end
    end

    // Shared adder operands: NEG forms Q-b, RED forms acc-Q with carry as acc>=Q
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state)
            S_NEG: begin
                add_x   = QX;
                add_y   = ~{1'b0, b_lane};
                add_cin = 1'b1;
            end
            S_ADD: begin
                add_x   = {1'b0, a_lane};
                add_y   = sub_reg ? acc : {1'b0, b_lane};
            end
            S_RED: begin
                add_x   = acc;
                add_y   = ~QX;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    assign {add_co, add_sum} = (NBITS+2)'(add_x) + (NBITS+2)'(add_y) + (NBITS+2)'(add_cin);
    assign red_val = add_co ? add_sum[NBITS-1:0] : acc[NBITS-1:0];

    // Edge detector; resets high so an en held through reset does not start
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) en_dly <= 1'b1;
        else       en_dly <= en;
    end

    // Capture the request so the caller may change inputs after the start cycle
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
        end else if (load) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
        end
    end

    // Lane counter
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                lane <= '0;
        else if (load)            lane <= '0;
        else if (do_red && !last) lane <= lane + 1'b1;
    end

    // Accumulator holds the negated b, then the unreduced sum
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)       acc <= '0;
        else if (do_neg) acc <= (b_lane == '0) ? '0 : add_sum;
        else if (do_add) acc <= add_sum;
    end

    // Result lanes: only the lane being reduced is written
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c <= '0;
        end else if (do_red) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane == LW'(i)) c[i*NBITS +: NBITS] <= red_val;
            end
        end
    end

    // Handshake outputs: ready drops after the start, returns one cycle after DONE
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
        end else begin
            ready_pulse <= fin;
            if (load)     ready <= 1'b0;
            else if (fin) ready <= 1'b1;
        end
    end

`ifdef FIELD_ADDSUB_RANGE_CHK_EN
    logic range_bad;

    // Any input operand at or above Q
    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if ({1'b0, a[i*NBITS +: NBITS]} >= QX) range_bad = 1'b1;
            if ({1'b0, b[i*NBITS +: NBITS]} >= QX) range_bad = 1'b1;
        end
    end

    // Range flag is re-evaluated at each start and held until the next one
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)     oor <= 1'b0;
        else if (load) oor <= range_bad;
    end
`endif

endmodule

// File: tb/tb_field_addsub_lanes.sv
// Directed bench for field_addsub_lanes with NBITS=8, Q=251, using one LANES=1
// and one LANES=4 instance. Define FIELD_ADDSUB_RANGE_CHK_EN to cover oor.
module tb_field_addsub_lanes;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;

    logic        en1 = 1'b1, sub1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        ready1, rp1;
    logic [7:0]  c1;

    logic        en4 = 1'b1, sub4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic        ready4, rp4;
    logic [31:0] c4;

`ifdef FIELD_ADDSUB_RANGE_CHK_EN
    logic        oor1, oor4;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    int np;

    always #5 clk = ~clk;

    field_addsub_lanes #(.NBITS(8), .Q(64'd251), .LANES(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .en(en1), .sub(sub1), .a(a1), .b(b1),
        .ready(ready1), .ready_pulse(rp1), .c(c1)
`ifdef FIELD_ADDSUB_RANGE_CHK_EN
        , .oor(oor1)
`endif
    );

    field_addsub_lanes #(.NBITS(8), .Q(64'd251), .LANES(4)) u_dut4 (
        .clk(clk), .rstb(rstb), .en(en4), .sub(sub4), .a(a4), .b(b4),
        .ready(ready4), .ready_pulse(rp4), .c(c4)
`ifdef FIELD_ADDSUB_RANGE_CHK_EN
        , .oor(oor4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic op1(input logic s, input logic [7:0] x, input logic [7:0] y, output int l);
        @(negedge clk);
        sub1 = s; a1 = x; b1 = y; en1 = 1'b1;
        @(posedge clk); #1;
        l = 1;
        en1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = ~s;
        while (!rp1 && l < 60) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic op4(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input bit tog, output int l, output int n);
        @(negedge clk);
        sub4 = s; a4 = x; b4 = y; en4 = 1'b1;
        @(posedge clk); #1;
        l = 1; n = 0;
        en4 = 1'b0; a4 = $urandom; b4 = $urandom; sub4 = ~s;
        while (!rp4 && l < 60) begin
            @(posedge clk); #1;
            l++;
            if (tog && l == 3) en4 = 1'b1;
            if (tog && l == 5) en4 = 1'b0;
        end
        if (rp4) n++;
        @(posedge clk); #1;
        if (rp4) n++;
    endtask

    initial begin
        // reset with en held high; release must not start a request
        #2 rstb = 1'b0;
        #1;
        chk("rst_ready1", ready1, 1);
        chk("rst_pulse1", rp1, 0);
        chk("rst_c1", c1, 0);
        chk("rst_ready4", ready4, 1);
        chk("rst_c4", c4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstb = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("en_held_ready1", ready1, 1);
        chk("en_held_ready4", ready4, 1);
        chk("en_held_c1", c1, 0);
`ifdef FIELD_ADDSUB_RANGE_CHK_EN
        chk("rst_oor1", oor1, 0);
`endif
        en1 = 1'b0; en4 = 1'b0;
        @(posedge clk);

        // single lane add and subtract
        op1(1'b0, 8'd200, 8'd100, lat);
        chk("add_c", c1, 49);
        chk("add_lat", lat, 4);
        chk("add_ready", ready1, 1);
        op1(1'b1, 8'd5, 8'd9, lat);
        chk("sub_5_9_c", c1, 247);
        chk("sub_5_9_lat", lat, 5);
        op1(1'b1, 8'd7, 8'd0, lat);
        chk("sub_7_0_c", c1, 7);
        chk("sub_7_0_lat", lat, 5);
        op1(1'b1, 8'd250, 8'd250, lat);
        chk("sub_250_c", c1, 0);
        chk("sub_250_lat", lat, 5);
        op1(1'b0, 8'd0, 8'd250, lat);
        chk("add_0_250_c", c1, 250);

        // four lanes, add
        op4(1'b0, {8'd250, 8'd0, 8'd1, 8'd125}, {8'd250, 8'd0, 8'd250, 8'd126}, 1'b0, lat, np);
        chk("l4_add_c", c4, {8'd249, 8'd0, 8'd0, 8'd0});
        chk("l4_add_lat", lat, 10);
        chk("l4_add_pulses", np, 1);

        // four lanes, subtract, with an en toggle while busy
        op4(1'b1, {8'd10, 8'd20, 8'd30, 8'd40}, {8'd20, 8'd10, 8'd30, 8'd0}, 1'b1, lat, np);
        chk("l4_sub_c", c4, {8'd241, 8'd10, 8'd0, 8'd40});
        chk("l4_sub_lat", lat, 14);
        chk("l4_sub_pulses", np, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("l4_toggle_idle", ready4, 1);
        chk("l4_toggle_c", c4, {8'd241, 8'd10, 8'd0, 8'd40});

        // reset while lane 2 is in its add step
        @(negedge clk);
        sub4 = 1'b0; a4 = {8'd9, 8'd9, 8'd9, 8'd9}; b4 = {8'd1, 8'd1, 8'd1, 8'd1}; en4 = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        en4 = 1'b0;
        while (lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mid_busy", ready4, 0);
        rstb = 1'b0;
        #1;
        chk("mid_rst_ready", ready4, 1);
        chk("mid_rst_c", c4, 0);
        chk("mid_rst_pulse", rp4, 0);
        @(posedge clk);
        @(negedge clk) rstb = 1'b1;
        op4(1'b0, {8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd250}, 1'b0, lat, np);
        chk("post_rst_c", c4, {8'd6, 8'd8, 8'd10, 8'd3});
        chk("post_rst_lat", lat, 10);

`ifdef FIELD_ADDSUB_RANGE_CHK_EN
        op1(1'b0, 8'd251, 8'd3, lat);
        chk("oor_set", oor1, 1);
        chk("oor_ready", ready1, 1);
        op1(1'b0, 8'd3, 8'd4, lat);
        chk("oor_clr", oor1, 0);
        chk("oor_clr_c", c1, 7);
        chk("oor4_inrange", oor4, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
